// File: rtl/obi_mem_responder_pkg.sv
// rtl/obi_mem_responder_pkg.sv - shared types and constants for the OBI memory responder
package obi_mem_responder_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: taps on bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;

endpackage

// File: rtl/obi_mem_lfsr.sv
// rtl/obi_mem_lfsr.sv - 16-bit Fibonacci LFSR with seed load during reset and an advance enable
module obi_mem_lfsr
  import obi_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  // An all-zero state would lock up, so a zero seed falls back to the default
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (en) begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

endmodule

// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - single-port word memory on a req/gnt/rvalid bus with random grant stalls
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned RESP_LATENCY = 1,
  parameter int unsigned STALL_MAX    = 7,
  parameter logic [31:0] ERR_RDATA    = 32'hBADACCE5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_en_i,
  input  logic [15:0] stall_seed_i
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned STALL_MOD = (STALL_MAX == 0) ? 1 : STALL_MAX;

  logic [31:0]   mem [MEM_WORDS];
  logic [15:0]   lfsr;
  stall_state_e  state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  resp_t         pipe_q [RESP_LATENCY];
  resp_t         push;
  logic [31:0]   rdata_hold_q;
  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          unused_bits;

  obi_mem_lfsr u_lfsr (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (1'b1),
    .seed (stall_seed_i),
    .lfsr (lfsr)
  );

  assign word_idx    = addr_i[31:2];
  assign in_range    = (32'(word_idx) < MEM_WORDS);
  assign mem_idx     = word_idx[AW-1:0];
  assign unused_bits = ^{lfsr[15:5], addr_i[1:0]};

  // Gating with rst_i keeps gnt_o low while reset holds the FSM in RUN
  assign gnt_o = req_i & ~rst_i & (state_q == RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (stall_en_i && (STALL_MAX != 0) && lfsr[0]) begin
          state_d = STALL;
          cnt_d   = 8'((32'(lfsr[4:1]) % STALL_MOD) + 32'd1);
        end
      end
      STALL: begin
        if (!stall_en_i || cnt_q == 8'd1) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    push       = '0;
    push.valid = gnt_o;
    push.err   = gnt_o & ~in_range;
    if (!we_i) begin
      push.rdata = in_range ? mem[mem_idx] : ERR_RDATA;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      rdata_hold_q <= '0;
      for (int i = 0; i < int'(RESP_LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pipe_q[0] <= push;
      for (int i = 1; i < int'(RESP_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (pipe_q[RESP_LATENCY-1].valid) begin
        rdata_hold_q <= pipe_q[RESP_LATENCY-1].rdata;
      end
    end
  end

  // Array contents survive reset; the bench preloads them
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rvalid_o = pipe_q[RESP_LATENCY-1].valid;
  assign err_o    = pipe_q[RESP_LATENCY-1].err;
  assign rdata_o  = rvalid_o ? pipe_q[RESP_LATENCY-1].rdata : rdata_hold_q;

endmodule
